// File: rtl/esc_spi_irq_in_pkg.sv
// Shared constants and helpers for the ESC SPI_IRQ input block.
package esc_spi_irq_in_pkg;

  // Avalon-MM word addresses of the register map.
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RAW     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Ceiling log2. Sizes the filter counter so it can hold FILTER_CYCLES-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << result) < value) result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/esc_irq_sync_filter.sv
// Two-flop synchronizer followed by a stability filter for an idle-high pin.
// The filtered level only changes after the synchronized level has disagreed
// with it for FILTER_CYCLES consecutive cycles.
module esc_irq_sync_filter
  import esc_spi_irq_in_pkg::*;
#(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out,
  output logic filt_out
);

  // A single-cycle filter still needs a one-bit counter to keep the types legal.
  localparam int CNT_W = (clog2(FILTER_CYCLES) < 1) ? 1 : clog2(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             filt;
  logic [CNT_W-1:0] cnt;

  // Synchronizer: the pin is asynchronous, so only s2 is used downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= async_in;
      s2 <= s1;
    end
  end

  // Filter: count cycles of disagreement; any return to agreement restarts
  // the count, so short pulses never reach filt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt <= 1'b1;
      cnt  <= '0;
    end else if (s2 == filt) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      filt <= s2;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sync_out = s2;
  assign filt_out = filt;

endmodule

// File: rtl/esc_spi_irq_in.sv
// Avalon-MM slave exposing the filtered ESC SPI_IRQ pin, an edge-capture
// latch and an interrupt mask. irq is edgecapture AND irqmask.
//
// Bus semantics: a transfer is valid when chipselect=1. A write (write_n=0)
// is accepted on that clk edge with no wait states; a read is a pure
// combinational decode of address, so readdata is valid in the same cycle.
module esc_spi_irq_in
  import esc_spi_irq_in_pkg::*;
#(
  parameter int FILTER_CYCLES  = 4,
  parameter int EDGE_FALLING   = 1,
  parameter int IRQ_RESET_MASK = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        in_port,
  output logic        irq
);

  logic raw_level;
  logic filt_level;
  logic filt_d;
  logic irqmask;
  logic edgecapture;
  logic wr_en;
  logic edge_set;
  logic edge_clr;
  logic unused_writedata;

  esc_irq_sync_filter #(
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_sync_filter (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (in_port),
    .sync_out (raw_level),
    .filt_out (filt_level)
  );

  assign wr_en = chipselect && !write_n;

  // Only the selected transition of the filtered level is captured.
  assign edge_set = (EDGE_FALLING != 0) ? (filt_d && !filt_level)
                                        : (!filt_d && filt_level);

  assign edge_clr = wr_en && (address == ADDR_EDGECAP) && writedata[0];

  // Only bit 0 of the write data is architecturally meaningful.
  assign unused_writedata = ^writedata[31:1];

  // Edge-detect delay register follows the filtered level by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_d <= 1'b1;
    end else begin
      filt_d <= filt_level;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= (IRQ_RESET_MASK != 0);
    end else if (wr_en && (address == ADDR_IRQMASK)) begin
      irqmask <= writedata[0];
    end
  end

  // Edge capture: set wins over a simultaneous write-1-to-clear so no edge
  // is ever lost; captures regardless of the mask.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecapture <= 1'b0;
    end else begin
      edgecapture <= edge_set || (edgecapture && !edge_clr);
    end
  end

  // Zero-wait-state read decode over registered state.
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DATA:    readdata[0] = filt_level;
      ADDR_RAW:     readdata[0] = raw_level;
      ADDR_IRQMASK: readdata[0] = irqmask;
      ADDR_EDGECAP: readdata[0] = edgecapture;
      default:      readdata = 32'd0;
    endcase
  end

  assign irq = edgecapture && irqmask;

endmodule

// File: tb/tb_esc_spi_irq_in.sv
// Directed bench for esc_spi_irq_in with default parameters
// (FILTER_CYCLES=4, EDGE_FALLING=1, IRQ_RESET_MASK=0).
module tb_esc_spi_irq_in;
  import esc_spi_irq_in_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        in_port;
  logic        irq;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  esc_spi_irq_in dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  // Clock and initial reset levels
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    in_port    = 1'b1;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] e;
    reset_n = 1'b0;
    in_port = 1'b1;
    ticks(3);
    reset_n = 1'b1;
    tick();
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e) begin
        errors++;
        $display("FAIL reset_addr%0d: got %0h expected %0h", a, rd, e);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %0b expected 0", irq);
    end
  endtask

  task automatic test_register_rw();
    logic [31:0] rd;
    bus_write(ADDR_IRQMASK, 32'hFFFF_FFFF);
    bus_read(ADDR_IRQMASK, rd);
    checks++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL rw_mask_upper_zero: got %0h expected 1", rd);
    end
    bus_write(ADDR_DATA, 32'd0);
    bus_read(ADDR_DATA, rd);
    checks++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL rw_data_ro: got %0h expected 1", rd);
    end
    bus_write(ADDR_RAW, 32'd0);
    bus_read(ADDR_RAW, rd);
    checks++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL rw_raw_ro: got %0h expected 1", rd);
    end
    bus_write(ADDR_IRQMASK, 32'd0);
    bus_read(ADDR_IRQMASK, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL rw_mask_clear: got %0h expected 0", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      bus_write(ADDR_IRQMASK, 32'(i % 2) | 32'h0000_0010);
      exp_q.push_back(32'(i % 2));
    end
    bus_read(ADDR_IRQMASK, rd);
    e = exp_q.pop_back();
    exp_q.delete();
    checks++;
    if (rd !== e) begin
      errors++;
      $display("FAIL b2b_last_write: got %0h expected %0h", rd, e);
    end
    bus_write(ADDR_IRQMASK, 32'd0);
  endtask

  task automatic test_edge_irq();
    logic [31:0] rd;
    bus_write(ADDR_IRQMASK, 32'd1);
    in_port = 1'b0;
    tick();
    bus_read(ADDR_RAW, rd);
    checks++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL edge_raw_e1: got %0h expected 1", rd);
    end
    tick();
    bus_read(ADDR_RAW, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL edge_raw_e2: got %0h expected 0", rd);
    end
    ticks(3);
    bus_read(ADDR_DATA, rd);
    checks++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL edge_data_e5: got %0h expected 1", rd);
    end
    tick();
    bus_read(ADDR_DATA, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL edge_data_e6: got %0h expected 0", rd);
    end
    bus_read(ADDR_EDGECAP, rd);
    checks++;
    if (rd !== 32'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL edge_cap_e6: got cap=%0h irq=%0b expected cap=0 irq=0", rd, irq);
    end
    tick();
    bus_read(ADDR_EDGECAP, rd);
    checks++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL edge_cap_e7: got %0h expected 1", rd);
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL edge_irq_e7: got %0b expected 1", irq);
    end
  endtask

  task automatic test_clear_race();
    logic [31:0] rd;
    bus_write(ADDR_EDGECAP, 32'd0);
    bus_read(ADDR_EDGECAP, rd);
    checks++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL clr_write0_noeffect: got %0h expected 1", rd);
    end
    bus_write(ADDR_EDGECAP, 32'd1);
    bus_read(ADDR_EDGECAP, rd);
    checks++;
    if (rd !== 32'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL clr_write1: got cap=%0h irq=%0b expected cap=0 irq=0", rd, irq);
    end
    in_port = 1'b1;
    ticks(8);
    bus_read(ADDR_DATA, rd);
    checks++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL clr_rise_data: got %0h expected 1", rd);
    end
    bus_read(ADDR_EDGECAP, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL clr_rise_not_captured: got %0h expected 0", rd);
    end
    in_port = 1'b0;
    ticks(6);
    bus_write(ADDR_EDGECAP, 32'd1);
    bus_read(ADDR_EDGECAP, rd);
    checks++;
    if (rd !== 32'd1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL race_set_wins: got cap=%0h irq=%0b expected cap=1 irq=1", rd, irq);
    end
    bus_write(ADDR_EDGECAP, 32'd1);
    bus_read(ADDR_EDGECAP, rd);
    checks++;
    if (rd !== 32'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL race_second_clear: got cap=%0h irq=%0b expected cap=0 irq=0", rd, irq);
    end
    in_port = 1'b1;
    ticks(8);
  endtask

  task automatic test_glitch();
    logic [31:0] rd0;
    logic [31:0] rd3;
    in_port = 1'b0;
    ticks(3);
    in_port = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      bus_read(ADDR_DATA, rd0);
      bus_read(ADDR_EDGECAP, rd3);
      checks++;
      if (rd0 !== 32'd1 || rd3 !== 32'd0) begin
        errors++;
        $display("FAIL glitch_cycle%0d: got data=%0h cap=%0h expected data=1 cap=0", i, rd0, rd3);
      end
    end
  endtask

  task automatic test_masked();
    logic [31:0] rd;
    bus_write(ADDR_IRQMASK, 32'd0);
    in_port = 1'b0;
    ticks(7);
    bus_read(ADDR_EDGECAP, rd);
    checks++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL masked_cap: got %0h expected 1", rd);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL masked_irq_low: got %0b expected 0", irq);
    end
    bus_write(ADDR_IRQMASK, 32'd1);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL masked_irq_unmask: got %0b expected 1", irq);
    end
    bus_write(ADDR_EDGECAP, 32'd1);
    in_port = 1'b1;
    ticks(8);
  endtask

  task automatic test_mid_reset();
    logic [31:0] rd;
    bus_write(ADDR_IRQMASK, 32'd1);
    in_port = 1'b0;
    ticks(4);
    reset_n = 1'b0;
    #1;
    bus_read(ADDR_RAW, rd);
    checks++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL midrst_raw_async: got %0h expected 1", rd);
    end
    bus_read(ADDR_IRQMASK, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL midrst_mask_async: got %0h expected 0", rd);
    end
    ticks(2);
    reset_n = 1'b1;
    ticks(5);
    bus_read(ADDR_DATA, rd);
    checks++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL midrst_data_e5: got %0h expected 1", rd);
    end
    tick();
    bus_read(ADDR_DATA, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL midrst_data_e6: got %0h expected 0", rd);
    end
    bus_read(ADDR_EDGECAP, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL midrst_cap_e6: got %0h expected 0", rd);
    end
    tick();
    bus_read(ADDR_EDGECAP, rd);
    checks++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL midrst_cap_e7: got %0h expected 1", rd);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL midrst_irq_masked: got %0b expected 0", irq);
    end
  endtask

  // Test sequence and final report
  initial begin
    #1;
    test_reset();
    test_register_rw();
    test_back_to_back();
    test_edge_irq();
    test_clear_race();
    test_glitch();
    test_masked();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/esc_spi_irq_in.md
ESC_SPI_IRQ_IN -- requirements
Module: esc_spi_irq_in

Interface
REQ-001 The block SHALL have parameter FILTER_CYCLES, default 4: the number of consecutive stable synchronized cycles required before the filtered level changes; legal range 1..255.
REQ-002 The block SHALL have parameter EDGE_FALLING, default 1: 1 captures 1->0 transitions of the filtered level, 0 captures 0->1 transitions.
REQ-003 The block SHALL have parameter IRQ_RESET_MASK, default 0: the reset value of irqmask bit 0.
REQ-004 The block SHALL have input clk, 1 bit, the system clock.
REQ-005 The block SHALL have input reset_n, 1 bit, the reset; reset_n is asynchronous and active-low.
REQ-006 The block SHALL have input address, 2 bits, the Avalon-MM word address.
REQ-007 The block SHALL have input chipselect, 1 bit, the Avalon-MM slave select.
REQ-008 The block SHALL have input write_n, 1 bit, the active-low write strobe.
REQ-009 The block SHALL have input writedata, 32 bits, the write data.
REQ-010 The block SHALL have output readdata, 32 bits, the read data; bits 31:1 are always 0.
REQ-011 The block SHALL have input in_port, 1 bit, the asynchronous ESC SPI_IRQ pin, idle high.
REQ-012 The block SHALL have output irq, 1 bit, an active-high interrupt to the CPU.

Function
REQ-013 Register map: addr0 = data (RO, filtered level); addr1 = raw (RO, synchronized level); addr2 = irqmask (R/W, bit 0); addr3 = edgecapture (R, write-1-to-clear bit 0).
REQ-014 Reads SHALL have zero wait states and latency 0: readdata is a combinational decode of address over registered state.
REQ-015 Writes SHALL take effect on the clk edge where chipselect=1 and write_n=0; writes to addr0 and addr1 are ignored.
REQ-016 in_port SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-017 Filter: when s2 equals filt, cnt SHALL be 0; when s2 differs from filt, cnt SHALL increment each cycle; when s2 differs and cnt = FILTER_CYCLES-1, filt SHALL load s2 and cnt SHALL load 0 on the same edge.
REQ-018 Any s2 pulse shorter than FILTER_CYCLES cycles SHALL leave filt unchanged, and cnt SHALL return to 0.
REQ-019 edgecapture SHALL set one cycle after filt makes the selected transition; for an in_port step meeting setup before edge 1, filt changes at edge FILTER_CYCLES+2 and edgecapture sets at edge FILTER_CYCLES+3.
REQ-020 If a set and a write-1-to-clear of edgecapture occur on the same edge, the set SHALL win.
REQ-021 Writing 0 to edgecapture bit 0 SHALL have no effect.
REQ-022 irq SHALL equal edgecapture AND irqmask and SHALL be glitch-free, being derived from registers only.
REQ-023 edgecapture SHALL set regardless of the irqmask value.

Reset
REQ-024 On reset_n=0, the block SHALL asynchronously set s1, s2, filt and the edge-detect delay register to 1, set cnt and edgecapture to 0, and set irqmask to IRQ_RESET_MASK; irq is 0 whenever edgecapture is 0.
REQ-025 Reset asserted mid-filter SHALL discard a partial count, and after release no edge SHALL be captured until a full FILTER_CYCLES qualification completes.

Structure
REQ-026 A shared package SHALL hold the register address constants (ADDR_DATA, ADDR_RAW, ADDR_IRQMASK, ADDR_EDGECAP) and a clog2 function that sizes cnt.
REQ-027 The synchronizer and filter SHALL form one sub-module, esc_irq_sync_filter (ports clk, reset_n, async_in, sync_out, filt_out); register decode and edge capture SHALL remain in the top module.

Verification
REQ-028 Reset check: after reset with defaults, reads SHALL return addr0=1, addr1=1, addr2=0, addr3=0, and irq SHALL be 0.
REQ-029 Edge and irq: with FILTER_CYCLES=4, write addr2=1, then drive in_port 1->0; edgecapture SHALL read 1 from edge 7, and irq SHALL rise at edge 7.
REQ-030 Glitch rejection: with FILTER_CYCLES=4, drive a 3-cycle low pulse on in_port; addr0 SHALL stay 1 and edgecapture SHALL stay 0.
REQ-031 Clear race: write addr3=0x1 on the same edge that edgecapture sets; edgecapture SHALL remain 1; a second write of 0x1 SHALL clear it, and irq SHALL drop on the following cycle.
REQ-032 Masked capture: with addr2=0, apply a falling edge; addr3 SHALL read 1 and irq SHALL stay 0; writing addr2=1 SHALL raise irq on the next edge.
REQ-033 Mid-filter reset: assert reset_n after in_port has been low for 2 qualified cycles, then release with in_port still low; filt SHALL go 0 and edgecapture SHALL set at FILTER_CYCLES+3 edges after release.
